if_prefetch: RTL

IF_PREFETCH -- requirements
Module: if_prefetch

---
 rtl/if_prefetch.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/if_prefetch.sv
// Instruction fetch prefetcher: keeps one outstanding memory read, queues fetched
// words with their pc+4, flushes on redirect and drops a stale in-flight reply.
module if_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        hold,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc4,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     fpc_q, fpc_d;
    logic [31:0]     addr_q, addr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     inst_mem_q [DEPTH];
    logic [31:0]     pc4_mem_q  [DEPTH];

    logic            pop_s;
    logic            push_s;
    logic [31:0]     fpc_plus4_s;
    logic [CW-1:0]   count_after_pop_s;
    logic [CW-1:0]   count_after_s;

    // Next-state logic for the fetch FSM, fetch PC, queue pointers and occupancy
    always_comb begin
        pop_s             = (count_q != {CW{1'b0}}) && !hold && !redirect;
        push_s            = (state_q == FETCH) && mem_ack && !redirect;
        fpc_plus4_s       = fpc_q + 32'd4;
        count_after_pop_s = count_q - CW'(pop_s);
        count_after_s     = count_after_pop_s + CW'(push_s);

        state_d = state_q;
        fpc_d   = fpc_q;
        rptr_d  = pop_s  ? rptr_q + AW'(1) : rptr_q;
        wptr_d  = push_s ? wptr_q + AW'(1) : wptr_q;
        count_d = count_after_s;

        case (state_q)
            IDLE: begin
                if (redirect || (count_after_pop_s < DEPTH_C)) begin
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                if (redirect) begin
                    state_d = mem_ack ? FETCH : DISCARD;
                end else if (mem_ack) begin
                    fpc_d   = fpc_plus4_s;
                    state_d = (count_after_s < DEPTH_C) ? FETCH : IDLE;
                end else begin
                    state_d = FETCH;
                end
            end
            DISCARD: begin
                if (mem_ack) begin
                    state_d = FETCH;
                end else begin
                    state_d = DISCARD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Redirect overrides everything: flush the queue and restart at the target
        if (redirect) begin
            fpc_d   = {redirect_pc[31:2], 2'b00};
            rptr_d  = {AW{1'b0}};
            wptr_d  = {AW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            fpc_d   = fpc_d;
        end

        // A stale request must keep its address until it is acked
        if (state_d == DISCARD) begin
            addr_d = addr_q;
        end else begin
            addr_d = fpc_d;
        end
    end

    // Control and pointer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fpc_q   <= RESET_PC;
            addr_q  <= RESET_PC;
            rptr_q  <= {AW{1'b0}};
            wptr_q  <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            addr_q  <= addr_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Queue storage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem_q[i] <= 32'h0000_0000;
                pc4_mem_q[i]  <= 32'h0000_0000;
            end
        end else if (push_s) begin
            inst_mem_q[wptr_q] <= mem_rdata;
            pc4_mem_q[wptr_q]  <= fpc_plus4_s;
        end else begin
            inst_mem_q[wptr_q] <= inst_mem_q[wptr_q];
            pc4_mem_q[wptr_q]  <= pc4_mem_q[wptr_q];
        end
    end

    assign inst_valid = (count_q != {CW{1'b0}});
    assign inst       = inst_valid ? inst_mem_q[rptr_q] : 32'h0000_0000;
    assign inst_pc4   = inst_valid ? pc4_mem_q[rptr_q]  : 32'h0000_0000;
    assign mem_req    = (state_q != IDLE);
    assign mem_addr   = addr_q;

endmodule
